// File: rtl/signed_display_scanner_pkg.sv
// Shared segment constants and scan state encoding for the signed display scanner.
// Segment vectors are active-low {a,b,c,d,e,f,g}, a is the MSB.
package signdisp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  localparam logic [6:0] SEG_DIGIT [0:8] = '{
    7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000
  };

  typedef enum logic {BLANK, SHOW} state_t;

endpackage

// File: rtl/sign_mag_encode.sv
// Combinational split of a 4-bit two's-complement value into sign and magnitude digit patterns.
// Zero latency; no flow control.
module sign_mag_encode
  import signdisp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] sign_seg,
  output logic [6:0] mag_seg
);

  logic [3:0] mag;

  // The 4-bit negation of -8 wraps back to 4'b1000, which reads as 8 unsigned.
  always_comb begin
    mag      = value[3] ? (~value + 4'd1) : value;
    sign_seg = value[3] ? SEG_MINUS : SEG_BLANK;
    mag_seg  = SEG_DIGIT[mag];
  end

endmodule

// File: rtl/signed_display_scanner.sv
// Scans NUM_VALUES signed nibbles onto a shared active-low 7-seg bus with blanking and a frame-synchronous double buffer.
// Outputs lag the scan state by one register; optional per-slot dimming is enabled with the SIGNDISP_DIM_EN macro.
module signed_display_scanner
  import signdisp_pkg::*;
#(
  parameter int NUM_VALUES   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_VALUES-1:0] values,
  input  logic                    load,
`ifdef SIGNDISP_DIM_EN
  input  logic [1:0]              bright,
`endif
  output logic [6:0]              seg,
  output logic [2*NUM_VALUES-1:0] dig_n,
  output logic                    frame_done,
  output logic                    upd_ack
);

  localparam int NUM_DIGITS  = 2 * NUM_VALUES;
  localparam int SHOW_CYCLES = PRESCALE - BLANK_CYCLES;
  localparam int PH_W        = $clog2(PRESCALE + 1);
  localparam int SL_W        = $clog2(NUM_DIGITS);

  state_t                  state, state_nxt;
  logic [PH_W-1:0]         phase, phase_nxt;
  logic [SL_W-1:0]         slot, slot_nxt;
  logic                    wrap;
  logic                    enter_show;

  logic [4*NUM_VALUES-1:0] active;
  logic [4*NUM_VALUES-1:0] staging;
  logic                    pending;

  logic [3:0]              cur_value;
  logic [6:0]              sign_seg, mag_seg;
  logic                    dig_on;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      phase <= '0;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase + PH_W'(1);
    slot_nxt   = slot;
    wrap       = 1'b0;
    enter_show = 1'b0;
    case (state)
      BLANK: begin
        if (phase == PH_W'(BLANK_CYCLES - 1)) begin
          state_nxt  = SHOW;
          phase_nxt  = '0;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (phase == PH_W'(SHOW_CYCLES - 1)) begin
          state_nxt = BLANK;
          phase_nxt = '0;
          if (slot == SL_W'(NUM_DIGITS - 1)) begin
            slot_nxt = '0;
            wrap     = 1'b1;
          end else begin
            slot_nxt = slot + SL_W'(1);
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        phase_nxt = '0;
      end
    endcase
  end

  // A load landing on the wrap edge bypasses staging so it is not held back a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= '0;
      staging <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        active  <= values;
        staging <= values;
      end else if (pending) begin
        active  <= staging;
      end
      pending <= 1'b0;
    end else if (load) begin
      staging <= values;
      pending <= 1'b1;
    end
  end

  always_comb begin
    cur_value = '0;
    for (int k = 0; k < NUM_VALUES; k++) begin
      if ((int'(slot) >> 1) == k) cur_value = active[4*k +: 4];
    end
  end

  sign_mag_encode u_encode (
    .value    (cur_value),
    .sign_seg (sign_seg),
    .mag_seg  (mag_seg)
  );

`ifdef SIGNDISP_DIM_EN
  localparam int QUARTER = SHOW_CYCLES / 4;

  logic [1:0]      bright_q;
  logic [PH_W-1:0] dim_limit;

  always_ff @(posedge clk) begin
    if (rst)             bright_q <= '0;
    else if (enter_show) bright_q <= bright;
  end

  // Quarter q is lit while q <= bright, i.e. phase below (bright+1) quarters.
  always_comb begin
    case (bright_q)
      2'd0:    dim_limit = PH_W'(QUARTER);
      2'd1:    dim_limit = PH_W'(2 * QUARTER);
      2'd2:    dim_limit = PH_W'(3 * QUARTER);
      default: dim_limit = PH_W'(4 * QUARTER);
    endcase
    dig_on = (state == SHOW) && (phase < dim_limit);
  end
`else
  always_comb dig_on = (state == SHOW);
`endif

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (state == SHOW) seg_nxt = slot[0] ? mag_seg : sign_seg;
    dig_nxt = ~({{(NUM_DIGITS-1){1'b0}}, dig_on} << slot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dig_n      <= '1;
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig_n      <= dig_nxt;
      frame_done <= wrap;
      upd_ack    <= wrap & (pending | load);
    end
  end

endmodule

// File: tb/tb_signed_display_scanner.sv
// Bench for signed_display_scanner: directed scenarios then random loads/resets against a frame-position model.
// Dimming is exercised when SIGNDISP_DIM_EN is defined.
module tb_signed_display_scanner;

  localparam int NV    = 2;
  localparam int PS    = 10;
  localparam int BL    = 2;
  localparam int SLOTS = 2 * NV;
  localparam int FRAME = SLOTS * PS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [8-1:0]  values = '0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic [3:0]    dig_n;
  logic          frame_done;
  logic          upd_ack;
`ifdef SIGNDISP_DIM_EN
  logic [1:0]    bright = 2'd3;
  int            m_bright = 0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: cycle index since reset release and the two buffers.
  int         m_t = 0;
  logic [7:0] m_active = '0;
  logic [7:0] m_staging = '0;
  bit         m_pending = 0;

  logic [6:0] digits [0:8] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000
  };

  signed_display_scanner #(
    .NUM_VALUES   (NV),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .values     (values),
    .load       (load),
`ifdef SIGNDISP_DIM_EN
    .bright     (bright),
`endif
    .seg        (seg),
    .dig_n      (dig_n),
    .frame_done (frame_done),
    .upd_ack    (upd_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pattern(int slot, logic [7:0] act);
    logic [3:0] nib;
    int v;
    nib = act[(slot / 2) * 4 +: 4];
    v = nib[3] ? int'(nib) - 16 : int'(nib);
    if (slot % 2 == 0) return (v < 0) ? 7'b1111110 : 7'b1111111;
    return digits[(v < 0) ? -v : v];
  endfunction

  task automatic tick();
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    bit         e_fd, e_ack;
    int p, sl, w;
    @(posedge clk);
    #1;
    if (rst) begin
      e_seg = 7'b1111111; e_dig = 4'b1111; e_fd = 0; e_ack = 0;
      m_active = '0; m_staging = '0; m_pending = 0; m_t = 0;
    end else begin
      p  = m_t % FRAME;
      sl = p / PS;
      w  = p % PS;
      e_seg = (w >= BL) ? pattern(sl, m_active) : 7'b1111111;
      e_dig = 4'b1111;
      if (w >= BL) begin
`ifdef SIGNDISP_DIM_EN
        if ((w - BL) / ((PS - BL) / 4) <= m_bright) e_dig[sl] = 1'b0;
        if (w == BL - 1) m_bright = int'(bright);
`else
        e_dig[sl] = 1'b0;
`endif
      end
`ifdef SIGNDISP_DIM_EN
      if (w == BL - 1) m_bright = int'(bright);
`endif
      e_fd  = (p == FRAME - 1);
      e_ack = e_fd && (m_pending || load);
      if (e_fd) begin
        if (load) m_active = values;
        else if (m_pending) m_active = m_staging;
        m_pending = 0;
      end else if (load) begin
        m_staging = values;
        m_pending = 1;
      end
      m_t++;
    end
    total += 4;
    assert (seg === e_seg) else begin
      bad++; $error("FAIL seg t=%0d observed=%b expected=%b", m_t, seg, e_seg);
    end
    assert (dig_n === e_dig) else begin
      bad++; $error("FAIL dig_n t=%0d observed=%b expected=%b", m_t, dig_n, e_dig);
    end
    assert (frame_done === e_fd) else begin
      bad++; $error("FAIL frame_done t=%0d observed=%b expected=%b", m_t, frame_done, e_fd);
    end
    assert (upd_ack === e_ack) else begin
      bad++; $error("FAIL upd_ack t=%0d observed=%b expected=%b", m_t, upd_ack, e_ack);
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  // Advance until the next edge lands on frame position pos.
  task automatic run_to(int pos);
    int guard;
    guard = 0;
    while ((m_t % FRAME) != pos && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    total++;
    assert ((m_t % FRAME) == pos) else begin
      bad++; $error("FAIL run_to observed=%0d expected=%0d", m_t % FRAME, pos);
    end
  endtask

  task automatic pulse_load(logic [7:0] v);
    values = v;
    load = 1'b1;
    tick();
    load = 1'b0;
    values = $urandom();
  endtask

  initial begin
    // Reset held three cycles, then one full frame of the power-on pattern.
    run(3);
    rst = 1'b0;
    run(FRAME + 5);

    // v1=-3, v0=7 committed at the next wrap, then shown for a frame.
    pulse_load(8'b1101_0111);
    run_to(0);
    run(FRAME);

    // -8 magnitude, with the load arriving exactly on the wrap edge.
    run_to(FRAME - 1);
    pulse_load(8'h58);
    run(FRAME + 3);

    // Two loads in one frame: only the latest is committed, one ack.
    run_to(3);
    pulse_load(8'h11);
    run(7);
    pulse_load(8'h22);
    run_to(0);
    run(FRAME);

    // Reset in slot 2 SHOW discards a pending load.
    pulse_load(8'h9C);
    run_to(2 * PS + BL + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2 * FRAME);

`ifdef SIGNDISP_DIM_EN
    bright = 2'd1;
    run(FRAME + PS);
`endif

    // Random loads, values, resets and brightness.
    for (int i = 0; i < 600; i++) begin
      values = $urandom();
      load = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 249) == 0);
`ifdef SIGNDISP_DIM_EN
      bright = $urandom_range(0, 3);
`endif
      tick();
    end
    load = 1'b0;
    rst = 1'b0;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_display_scanner.md
Name: signed_display_scanner

Overview:
- Time-multiplexes NUM_VALUES 4-bit two's-complement values onto one shared, active-low seven-segment bus.
- Each value occupies two digit positions: a sign digit and a magnitude digit.
- The block schedules digit slots, inserts anti-ghosting blanking, and double-buffers updates so a frame never tears.
- It sits between the lab datapath registers and the board's segment and digit-enable pins.

Parameters:
- NUM_VALUES, 4, number of signed 4-bit values displayed (2*NUM_VALUES digit positions).
- PRESCALE, 50000, clock cycles per digit slot. Legal range: PRESCALE > BLANK_CYCLES.
- BLANK_CYCLES, 16, leading cycles of each slot with all digits disabled. Must be >= 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- values  in  4*NUM_VALUES  value k at bits [4k+3:4k], two's complement.
- load  in  1  one-cycle strobe; captures values into the staging buffer.
- seg  out  7  active-low segments {a,b,c,d,e,f,g}, a is the MSB.
- dig_n  out  2*NUM_VALUES  active-low digit enables. dig_n[2k] is the sign digit of value k; dig_n[2k+1] is its magnitude digit.
- frame_done  out  1  one-cycle pulse when slot wraps to 0.
- upd_ack  out  1  one-cycle pulse when staging is committed to the active buffer.

Behaviour:
- Clock/reset: single clock domain; Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - seg=7'b1111111, dig_n all 1, frame_done=0, upd_ack=0.
  - slot=0, state=BLANK, phase counter=0.
  - active buffer=0, staging buffer=0, pending=0.
- States:
  - BLANK: exactly BLANK_CYCLES cycles; dig_n all 1, seg=1111111. Then go to SHOW.
  - SHOW: exactly PRESCALE-BLANK_CYCLES cycles; dig_n has only bit [slot] low, seg shows the slot's pattern.
  - At the end of SHOW: slot increments and state returns to BLANK. When slot = 2*NUM_VALUES-1, slot wraps to 0.
- Latency after reset release: the first SHOW cycle (dig_n[0]=0) occurs BLANK_CYCLES cycles after the first non-reset edge. A slot period is PRESCALE cycles; a frame is 2*NUM_VALUES*PRESCALE cycles.
- Sign digit: 1111110 (g lit) if the MSB of the value is 1, else 1111111.
- Magnitude digit: |v| is computed as a 4-bit result so that -8 gives 8. Patterns:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010
  - 3 = 0000110, 4 = 1001100, 5 = 0100100
  - 6 = 0100000, 7 = 0001111, 8 = 0000000
- Load:
  - On load, staging <= values and pending <= 1.
  - A repeated load before commit overwrites staging (latest wins); only one upd_ack is produced.
- Commit (wrap edge, i.e. last SHOW cycle of slot 2*NUM_VALUES-1 into BLANK of slot 0):
  - frame_done pulses for one cycle.
  - If pending: active <= staging, pending <= 0, and upd_ack pulses in the same cycle as frame_done.
  - If load coincides with the wrap edge, the fresh values are committed directly, pending ends at 0, and upd_ack pulses.
- Segment data: seg is sourced only from the active buffer, never from values or staging.
- Reset mid-operation: on the next edge all outputs and state return to their reset values. Staging and pending are discarded.

Optional Feature:
- Macro: SIGNDISP_DIM_EN.
- Defined:
  - Adds port bright, input, width 2.
  - SHOW is split into four equal quarters; (PRESCALE-BLANK_CYCLES) must be divisible by 4.
  - The slot's digit enable is low only in quarters q <= bright. seg still shows the slot pattern for the whole of SHOW.
  - bright is sampled once, on entry to SHOW.
- Undefined: no bright port; the digit is enabled for the full SHOW window.

Decomposition:
- Package signdisp_pkg holds:
  - SEG_BLANK, SEG_MINUS, SEG_DIGIT[0:8] constants.
  - The state enum {BLANK, SHOW}.
- Sub-module sign_mag_encode: combinational 4-bit in, sign_seg[6:0] and mag_seg[6:0] out, using the package constants.
- The scanner holds the FSM, counters, slot index, buffers and muxing.

Test Plan:
All scenarios use NUM_VALUES=2, PRESCALE=10, BLANK_CYCLES=2 (frame = 40 cycles).
1. Reset held 3 cycles then released:
   - 2 cycles of dig_n=1111, seg=1111111.
   - Then 8 cycles of dig_n=1110, seg=1111111.
   - Then 2 blank cycles, then 8 cycles of dig_n=1101, seg=0000001.
2. load with values=8'b1101_0111 (v1=-3, v0=7):
   - At the next wrap, upd_ack and frame_done pulse together.
   - Following frame shows: slot0 1111111, slot1 0001111, slot2 1111110, slot3 0000110.
3. v0=4'b1000: slot0 seg=1111110, slot1 seg=0000000 (-8).
4. load 8'h11 then load 8'h22 within one frame: exactly one upd_ack; the next frame shows 2,2 with positive signs.
5. Reset asserted at cycle 5 of slot 2 SHOW: next cycle dig_n=1111, frame_done=0, upd_ack=0; slot 0 resumes after 2 blank cycles; the pending load is lost.
6. SIGNDISP_DIM_EN with bright=2'd1: each slot's dig_n bit is low for 4 of 8 SHOW cycles (first two quarters) and high for the remaining 4.
